// File: rtl/dac_frame_receiver_if.sv
// Frame bus from the SWV waveform engine to the DAC frame receiver.
//   dac_data    : frame byte
//   dac_data_en : byte-valid level
//   dac_set     : commit strobe level (rising edge acts)
// master = engine side, slave = receiver side.
interface dac_frame_receiver_if;
  logic [7:0] dac_data;
  logic       dac_data_en;
  logic       dac_set;

  modport master (
    output dac_data,
    output dac_data_en,
    output dac_set
  );

  modport slave (
    input dac_data,
    input dac_data_en,
    input dac_set
  );
endinterface : dac_frame_receiver_if

// File: rtl/dac_frame_receiver.sv
// dac_frame_receiver
// Captures a 3-byte DAC frame into a shadow register, commits the two 12-bit
// codes on the rising edge of dac_set and shifts them MSB-first to a
// dual-channel 12-bit serial DAC (channel A = re, channel B = ref).
//
// Build option: DAC_RX_REF_CHANNEL_EN
//   defined     : word A then word B are shifted per commit
//   not defined : only word A is shifted; ref_code is still latched
//
// Ports
//   ti_clk, rst_n       : clock, asynchronous active-low reset
//   bus (slave)         : dac_data / dac_data_en / dac_set frame bus
//   err_clr             : synchronous clear of sticky error flags
//   sclk, sync_n, sdin  : serial DAC pins (sclk idles low, sync_n active low)
//   busy, done          : transfer in progress / one-cycle completion pulse
//   re_code, ref_code   : last committed channel A / channel B codes
//   frame_err, overrun  : sticky framing / commit-while-busy errors
module dac_frame_receiver #(
  parameter int unsigned SCLK_DIV = 2,
  parameter int unsigned SYNC_GAP = 4
) (
  input  logic                   ti_clk,
  input  logic                   rst_n,
  dac_frame_receiver_if.slave    bus,
  input  logic                   err_clr,
  output logic                   sclk,
  output logic                   sync_n,
  output logic                   sdin,
  output logic                   busy,
  output logic                   done,
  output logic [11:0]            re_code,
  output logic [11:0]            ref_code,
  output logic                   frame_err,
  output logic                   overrun
);

  localparam int unsigned CODE_W = 12;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned DIV_W  = 8;
  localparam int unsigned BIT_W  = 4;
  localparam int unsigned CNT_W  = 2;
  localparam int unsigned GAP_W  = (SYNC_GAP > 1) ? $clog2(SYNC_GAP + 1) : 1;

`ifdef DAC_RX_REF_CHANNEL_EN
  localparam bit REF_EN = 1'b1;
`else
  localparam bit REF_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_GAP   = 2'd3
  } state_e;

  state_e              state_q,     state_d;
  logic                en_q,        en_d;
  logic                set_q,       set_d;
  logic [CNT_W-1:0]    cnt_q,       cnt_d;
  logic [BYTE_W-1:0]   byte0_q,     byte0_d;
  logic [BYTE_W-1:0]   byte1_q,     byte1_d;
  logic [BYTE_W-1:0]   byte2_q,     byte2_d;
  logic [CODE_W-1:0]   re_code_q,   re_code_d;
  logic [CODE_W-1:0]   ref_code_q,  ref_code_d;
  logic                frame_err_q, frame_err_d;
  logic                overrun_q,   overrun_d;
  logic                sclk_q,      sclk_d;
  logic                sync_n_q,    sync_n_d;
  logic                sdin_q,      sdin_d;
  logic                busy_q,      busy_d;
  logic                done_q,      done_d;
  logic                chan_b_q,    chan_b_d;
  logic [WORD_W-1:0]   shift_q,     shift_d;
  logic [DIV_W-1:0]    div_q,       div_d;
  logic [BIT_W-1:0]    bit_q,       bit_d;
  logic [GAP_W-1:0]    gap_q,       gap_d;

  logic                en_rise_c;
  logic                set_rise_c;
  logic                fe_set_c;
  logic                ov_set_c;
  logic                start_c;
  logic [CODE_W-1:0]   new_re_c;
  logic [CODE_W-1:0]   new_ref_c;

  // Next-state, capture, commit and serializer logic
  always_comb begin
    state_d     = state_q;
    en_d        = bus.dac_data_en;
    set_d       = bus.dac_set;
    cnt_d       = cnt_q;
    byte0_d     = byte0_q;
    byte1_d     = byte1_q;
    byte2_d     = byte2_q;
    re_code_d   = re_code_q;
    ref_code_d  = ref_code_q;
    sclk_d      = sclk_q;
    sync_n_d    = sync_n_q;
    sdin_d      = sdin_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    chan_b_d    = chan_b_q;
    shift_d     = shift_q;
    div_d       = div_q;
    bit_d       = bit_q;
    gap_d       = gap_q;
    fe_set_c    = 1'b0;
    ov_set_c    = 1'b0;
    start_c     = 1'b0;

    en_rise_c   = bus.dac_data_en & ~en_q;
    set_rise_c  = bus.dac_set & ~set_q;
    new_re_c    = {byte0_q, byte1_q[7:4]};
    new_ref_c   = {byte1_q[3:0], byte2_q};

    // Byte capture: a new en level starts a frame; a partial frame left behind is an error
    if (en_rise_c) begin
      if ((cnt_q == CNT_W'(1)) || (cnt_q == CNT_W'(2))) begin
        fe_set_c = 1'b1;
      end
      byte0_d = bus.dac_data;
      cnt_d   = CNT_W'(1);
    end else if (bus.dac_data_en && en_q) begin
      unique case (cnt_q)
        CNT_W'(0): begin byte0_d = bus.dac_data; cnt_d = CNT_W'(1); end
        CNT_W'(1): begin byte1_d = bus.dac_data; cnt_d = CNT_W'(2); end
        CNT_W'(2): begin byte2_d = bus.dac_data; cnt_d = CNT_W'(3); end
        default:   fe_set_c = 1'b1;
      endcase
    end

    // Commit: a running transfer always wins, so its codes stay intact
    if (set_rise_c) begin
      cnt_d = '0;
      if (busy_q) begin
        ov_set_c = 1'b1;
      end else if (cnt_q != CNT_W'(3)) begin
        fe_set_c = 1'b1;
      end else begin
        start_c    = 1'b1;
        re_code_d  = new_re_c;
        ref_code_d = new_ref_c;
      end
    end

    frame_err_d = fe_set_c | (frame_err_q & ~err_clr);
    overrun_d   = ov_set_c | (overrun_q & ~err_clr);

    unique case (state_q)
      S_IDLE: begin
        if (start_c) begin
          state_d  = S_LOAD;
          busy_d   = 1'b1;
          sync_n_d = 1'b0;
          chan_b_d = 1'b0;
          shift_d  = {2'b00, 2'b00, new_re_c};
          sdin_d   = shift_d[WORD_W-1];
        end
      end

      S_LOAD: begin
        state_d = S_SHIFT;
        sclk_d  = 1'b0;
        div_d   = '0;
        bit_d   = '0;
      end

      // sclk toggles every SCLK_DIV cycles; data moves only on the falling edge
      S_SHIFT: begin
        if (div_q == DIV_W'(SCLK_DIV - 1)) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          if (sclk_q) begin
            if (bit_q == BIT_W'(WORD_W - 1)) begin
              state_d  = S_GAP;
              sync_n_d = 1'b1;
              sdin_d   = 1'b0;
              gap_d    = '0;
            end else begin
              bit_d   = bit_q + BIT_W'(1);
              shift_d = {shift_q[WORD_W-2:0], 1'b0};
              sdin_d  = shift_q[WORD_W-2];
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      S_GAP: begin
        if (gap_q == GAP_W'(SYNC_GAP - 1)) begin
          if (REF_EN && !chan_b_q) begin
            state_d  = S_LOAD;
            chan_b_d = 1'b1;
            sync_n_d = 1'b0;
            shift_d  = {2'b01, 2'b00, ref_code_q};
            sdin_d   = shift_d[WORD_W-1];
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge ti_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      en_q        <= 1'b0;
      set_q       <= 1'b0;
      cnt_q       <= '0;
      byte0_q     <= '0;
      byte1_q     <= '0;
      byte2_q     <= '0;
      re_code_q   <= '0;
      ref_code_q  <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      sclk_q      <= 1'b0;
      sync_n_q    <= 1'b1;
      sdin_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      chan_b_q    <= 1'b0;
      shift_q     <= '0;
      div_q       <= '0;
      bit_q       <= '0;
      gap_q       <= '0;
    end else begin
      state_q     <= state_d;
      en_q        <= en_d;
      set_q       <= set_d;
      cnt_q       <= cnt_d;
      byte0_q     <= byte0_d;
      byte1_q     <= byte1_d;
      byte2_q     <= byte2_d;
      re_code_q   <= re_code_d;
      ref_code_q  <= ref_code_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      sclk_q      <= sclk_d;
      sync_n_q    <= sync_n_d;
      sdin_q      <= sdin_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      chan_b_q    <= chan_b_d;
      shift_q     <= shift_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      gap_q       <= gap_d;
    end
  end

  assign sclk      = sclk_q;
  assign sync_n    = sync_n_q;
  assign sdin      = sdin_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign re_code   = re_code_q;
  assign ref_code  = ref_code_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule : dac_frame_receiver

// File: tb/tb_dac_frame_receiver.sv
// Directed self-checking bench for dac_frame_receiver (SCLK_DIV=2, SYNC_GAP=4).
module tb_dac_frame_receiver;

`ifdef DAC_RX_REF_CHANNEL_EN
  localparam int N_WORDS = 2;
`else
  localparam int N_WORDS = 1;
`endif
  localparam int WORD_CYC = 1 + 32 * 2 + 4;
  localparam int XFER_CYC = N_WORDS * WORD_CYC;

  logic        ti_clk = 1'b0;
  logic        rst_n  = 1'b0;
  logic        err_clr = 1'b0;
  logic        sclk, sync_n, sdin, busy, done, frame_err, overrun;
  logic [11:0] re_code, ref_code;

  int errors = 0;
  int checks = 0;

  dac_frame_receiver_if bus ();

  dac_frame_receiver #(
    .SCLK_DIV (2),
    .SYNC_GAP (4)
  ) dut (
    .ti_clk    (ti_clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .err_clr   (err_clr),
    .sclk      (sclk),
    .sync_n    (sync_n),
    .sdin      (sdin),
    .busy      (busy),
    .done      (done),
    .re_code   (re_code),
    .ref_code  (ref_code),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 ti_clk = ~ti_clk;

  // Serial monitor: rebuilds each sync_n-low word from sdin at sclk rising edges
  logic [15:0] mon_sr = '0;
  int          mon_bits = 0;
  int          sync_falls = 0;
  logic        sclk_prev = 1'b0;
  logic        sync_prev = 1'b1;
  logic [15:0] words [$];
  int          wbits [$];

  always @(negedge ti_clk) begin
    if (sync_prev === 1'b1 && sync_n === 1'b0) begin
      mon_sr = '0;
      mon_bits = 0;
      sync_falls++;
    end
    if (sync_n === 1'b0 && sclk === 1'b1 && sclk_prev === 1'b0) begin
      mon_sr = {mon_sr[14:0], sdin};
      mon_bits++;
    end
    if (sync_prev === 1'b0 && sync_n === 1'b1) begin
      words.push_back(mon_sr);
      wbits.push_back(mon_bits);
    end
    sclk_prev = sclk;
    sync_prev = sync_n;
  end

  task automatic send_bytes(input int n, input logic [31:0] pk);
    for (int i = 0; i < n; i++) begin
      @(negedge ti_clk);
      bus.dac_data    = pk[31-8*i -: 8];
      bus.dac_data_en = 1'b1;
    end
    @(negedge ti_clk);
    bus.dac_data_en = 1'b0;
    bus.dac_data    = 8'h00;
  endtask

  // Returns at the first negedge after the commit edge
  task automatic pulse_set();
    @(negedge ti_clk);
    bus.dac_set = 1'b1;
    @(negedge ti_clk);
    bus.dac_set = 1'b0;
  endtask

  task automatic pulse_err_clr();
    @(negedge ti_clk);
    err_clr = 1'b1;
    @(negedge ti_clk);
    err_clr = 1'b0;
  endtask

  // cyc = number of clock edges after the commit edge until done is seen
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 2000) begin
      @(negedge ti_clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge ti_clk);
    checks++;
    if ({sclk, sync_n, sdin, busy, done} !== 5'b01000) begin
      errors++;
      $display("FAIL reset_pins: sclk,sync_n,sdin,busy,done=%b expected 01000", {sclk, sync_n, sdin, busy, done});
    end
    checks++;
    if ({re_code, ref_code} !== 24'h0 || {frame_err, overrun} !== 2'b00) begin
      errors++;
      $display("FAIL reset_regs: codes=%h errs=%b expected 000000 00", {re_code, ref_code}, {frame_err, overrun});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge ti_clk);
  endtask

  task automatic test_frame(input string name, input logic [23:0] frame,
                            input logic [11:0] exp_re, input logic [11:0] exp_ref);
    int base;
    int cyc;
    int nw;
    logic [15:0] exp_w [2];
    exp_w[0] = {4'b0000, exp_re};
    exp_w[1] = {4'b0100, exp_ref};
    base = words.size();
    send_bytes(3, {frame, 8'h00});
    pulse_set();
    checks++;
    if (busy !== 1'b1 || sync_n !== 1'b0) begin
      errors++;
      $display("FAIL %s_start: busy=%b sync_n=%b expected busy=1 sync_n=0", name, busy, sync_n);
    end
    checks++;
    if (re_code !== exp_re || ref_code !== exp_ref) begin
      errors++;
      $display("FAIL %s_codes: re=%h ref=%h expected re=%h ref=%h", name, re_code, ref_code, exp_re, exp_ref);
    end
    wait_done(cyc);
    checks++;
    if (cyc !== XFER_CYC) begin
      errors++;
      $display("FAIL %s_done_time: done after %0d cycles expected %0d", name, cyc, XFER_CYC);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy_at_done: busy=%b expected 0", name, busy);
    end
    @(negedge ti_clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s_done_pulse: done=%b one cycle later expected 0", name, done);
    end
    repeat (2) @(negedge ti_clk);
    nw = words.size() - base;
    checks++;
    if (nw !== N_WORDS) begin
      errors++;
      $display("FAIL %s_word_count: got %0d words expected %0d", name, nw, N_WORDS);
    end
    for (int i = 0; i < nw && i < 2; i++) begin
      checks++;
      if (words[base+i] !== exp_w[i] || wbits[base+i] !== 16) begin
        errors++;
        $display("FAIL %s_word%0d: got %h (%0d bits) expected %h (16 bits)", name, i, words[base+i], wbits[base+i], exp_w[i]);
      end
    end
  endtask

  task automatic test_short_frame();
    int falls0;
    falls0 = sync_falls;
    send_bytes(2, 32'hDEAD0000);
    pulse_set();
    repeat (20) @(negedge ti_clk);
    checks++;
    if (frame_err !== 1'b1 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL short_frame_err: frame_err=%b overrun=%b expected 1 0", frame_err, overrun);
    end
    checks++;
    if (sync_falls !== falls0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL short_no_xfer: sync_n falls=%0d busy=%b expected 0 falls busy=0", sync_falls - falls0, busy);
    end
    checks++;
    if (re_code !== 12'h800 || ref_code !== 12'hFFF) begin
      errors++;
      $display("FAIL short_codes_kept: re=%h ref=%h expected 800 fff", re_code, ref_code);
    end
    pulse_err_clr();
    checks++;
    if (frame_err !== 1'b0) begin
      errors++;
      $display("FAIL short_err_clr: frame_err=%b expected 0", frame_err);
    end
  endtask

  task automatic test_long_frame();
    send_bytes(4, 32'h12345678);
    checks++;
    if (frame_err !== 1'b1) begin
      errors++;
      $display("FAIL long_frame_err: frame_err=%b expected 1", frame_err);
    end
    pulse_err_clr();
    checks++;
    if (frame_err !== 1'b0) begin
      errors++;
      $display("FAIL long_err_clr: frame_err=%b expected 0", frame_err);
    end
    // Shadow must still hold the first three bytes
    begin
      int base;
      int cyc;
      base = words.size();
      pulse_set();
      checks++;
      if (re_code !== 12'h123 || ref_code !== 12'h456) begin
        errors++;
        $display("FAIL long_codes: re=%h ref=%h expected 123 456", re_code, ref_code);
      end
      wait_done(cyc);
      repeat (3) @(negedge ti_clk);
      checks++;
      if (words.size() - base !== N_WORDS || words[base] !== 16'h0123) begin
        errors++;
        $display("FAIL long_word_a: words=%0d first=%h expected %0d 0123", words.size() - base,
                 (words.size() > base) ? words[base] : 16'hxxxx, N_WORDS);
      end
    end
  endtask

  task automatic test_overrun();
    int base;
    int falls0;
    int cyc;
    logic [15:0] exp_w [2];
    exp_w[0] = 16'h0555;
    exp_w[1] = 16'h4AA5;
    base = words.size();
    falls0 = sync_falls;
    send_bytes(3, 32'h555AA500);
    pulse_set();
    repeat (10) @(negedge ti_clk);
    send_bytes(3, 32'h11223300);
    pulse_set();
    checks++;
    if (overrun !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL overrun_flag: overrun=%b busy=%b expected 1 1", overrun, busy);
    end
    checks++;
    if (re_code !== 12'h555 || ref_code !== 12'hAA5) begin
      errors++;
      $display("FAIL overrun_codes: re=%h ref=%h expected 555 aa5", re_code, ref_code);
    end
    wait_done(cyc);
    repeat (150) @(negedge ti_clk);
    checks++;
    if (sync_falls - falls0 !== N_WORDS || words.size() - base !== N_WORDS) begin
      errors++;
      $display("FAIL overrun_no_second: sync falls=%0d words=%0d expected %0d", sync_falls - falls0, words.size() - base, N_WORDS);
    end
    for (int i = 0; i < words.size() - base && i < 2; i++) begin
      checks++;
      if (words[base+i] !== exp_w[i]) begin
        errors++;
        $display("FAIL overrun_word%0d: got %h expected %h", i, words[base+i], exp_w[i]);
      end
    end
    pulse_err_clr();
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clr: overrun=%b expected 0", overrun);
    end
  endtask

  task automatic test_reset_mid();
    int rises;
    int n;
    logic prev;
    send_bytes(3, 32'h9ABCDE00);
    pulse_set();
    rises = 0;
    n = 0;
    prev = sclk;
    while (rises < 8 && n < 500) begin
      @(negedge ti_clk);
      n++;
      if (sclk === 1'b1 && prev === 1'b0) rises++;
      prev = sclk;
    end
    checks++;
    if (rises !== 8 || sync_n !== 1'b0) begin
      errors++;
      $display("FAIL mid_reach_8th_sclk: rises=%0d sync_n=%b expected 8 0", rises, sync_n);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sync_n, sclk, busy, sdin, done} !== 5'b10000) begin
      errors++;
      $display("FAIL mid_reset_pins: sync_n,sclk,busy,sdin,done=%b expected 10000", {sync_n, sclk, busy, sdin, done});
    end
    checks++;
    if ({re_code, ref_code} !== 24'h0) begin
      errors++;
      $display("FAIL mid_reset_codes: codes=%h expected 000000", {re_code, ref_code});
    end
    @(negedge ti_clk);
    rst_n = 1'b1;
    repeat (20) @(negedge ti_clk);
    checks++;
    if (sync_n !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_stay_idle: sync_n=%b busy=%b expected 1 0", sync_n, busy);
    end
  endtask

  initial begin
    bus.dac_data    = 8'h00;
    bus.dac_data_en = 1'b0;
    bus.dac_set     = 1'b0;
    test_reset();
    test_frame("frame_abc123", 24'hABC123, 12'hABC, 12'h123);
    test_frame("frame_800fff", 24'h800FFF, 12'h800, 12'hFFF);
    test_short_frame();
    test_long_frame();
    test_overrun();
    test_reset_mid();
    test_frame("after_reset", 24'h5A0F3C, 12'h5A0, 12'hF3C);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_dac_frame_receiver

// File: doc/dac_frame_receiver.md
# dac_frame_receiver

Receiving end of the 3-byte DAC frame bus (`dac_data` / `dac_data_en` / `dac_set`) driven by the SWV engine. It captures the frame into a shadow register and, on `dac_set`, commits the two 12-bit codes. It then shifts them MSB-first to a dual-channel 12-bit serial DAC: channel A is the working-electrode voltage `re`, channel B is the ADC reference `ref`. The block sits between the waveform engine and the board DAC pins and reports framing and overrun errors.

## Interface
- `SCLK_DIV`, default 2: `ti_clk` cycles per `sclk` half-period; legal range 1–255.
- `SYNC_GAP`, default 4: `ti_clk` cycles `sync_n` stays high between the two words; legal range ≥ 1.
- `ti_clk` in 1: sole clock; all logic is on the rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `dac_data` in 8: frame byte.
- `dac_data_en` in 1: byte-valid, level.
- `dac_set` in 1: commit strobe, level; only the rising edge acts.
- `err_clr` in 1: synchronous clear of sticky error flags.
- `sclk` out 1: DAC serial clock, idles low.
- `sync_n` out 1: DAC frame sync, active low.
- `sdin` out 1: DAC serial data.
- `busy` out 1: serial transfer in progress.
- `done` out 1: one-cycle pulse when the transfer completes.
- `re_code` out 12: last committed channel-A code.
- `ref_code` out 12: last committed channel-B code.
- `frame_err` out 1: sticky framing error.
- `overrun` out 1: sticky commit-while-busy error.

## Operation
- Frame layout:
  - byte0 = `re[11:4]`
  - byte1 = {`re[3:0]`, `ref[11:8]`}
  - byte2 = `ref[7:0]`
- Capture:
  - Rising edge of `dac_data_en` (registered compare): write byte to index 0, set `cnt` to 1.
  - If the previous `cnt` was 1 or 2 at that edge, set `frame_err` (abandoned frame).
  - While `en` stays high and `cnt` < 3: write byte at index `cnt`, increment `cnt`.
  - If `en` is high with `cnt` = 3, set `frame_err` and ignore the byte.
  - `cnt` holds while `en` is low.
- Commit on `dac_set` rising edge:
  - `cnt` = 3 and not busy: latch `re_code`/`ref_code`, clear `cnt` to 0, start transfer.
  - `cnt` ≠ 3: set `frame_err`, clear `cnt`, no transfer, outputs unchanged.
  - `busy` = 1: set `overrun`, clear `cnt`, discard the frame; the running transfer continues with its original codes.
- Serial word, 16 bits MSB-first: [15:14] channel (00 = A, 01 = B), [13:12] = 00, [11:0] code.
- FSM:
  - IDLE: on commit → LOAD.
  - LOAD (1 cycle): `sync_n` ← 0, load word A into the shifter, `sdin` = bit 15 → SHIFT.
  - SHIFT: 16 `sclk` periods; `sclk` rises every `SCLK_DIV` cycles and falls `SCLK_DIV` cycles later. `sdin` changes only on the falling edge of `sclk`, so the DAC samples on the rising edge. After the 16th falling edge: `sync_n` ← 1 → GAP.
  - GAP: hold `SYNC_GAP` cycles. Then, if word B is pending → LOAD; otherwise → IDLE and pulse `done`.
- `busy` is high from LOAD through the end of the last GAP.
- `err_clr` clears both sticky flags; a set event in the same cycle wins.
- Reset: `sclk` 0, `sync_n` 1, `sdin` 0, `busy` 0, `done` 0, `re_code` 0, `ref_code` 0, `frame_err` 0, `overrun` 0, `cnt` 0, FSM IDLE.
- Reset mid-transfer: all outputs return to their reset values immediately; the partial word is abandoned.

## Timing
- `dac_set` rising edge sampled at cycle N:
  - `busy` = 1 and `sync_n` = 0 at N+1
  - codes visible on `re_code`/`ref_code` at N+1
- One word occupies 1 + 32·`SCLK_DIV` cycles with `sync_n` low.
- Total with both channels: 2·(1 + 32·`SCLK_DIV` + `SYNC_GAP`) cycles. `done` is asserted in the last cycle and `busy` falls in the same cycle.
- Bytes are sampled on the rising edge; the engine drives on the falling edge, giving half a cycle of setup.

## Configuration
- `DAC_RX_REF_CHANNEL_EN` defined: both words (A, then B) are shifted, as above.
- Not defined:
  - Only word A is shifted; the FSM goes GAP → IDLE after word A.
  - `ref_code` is still latched from the frame.
  - Total transfer is 1 + 32·`SCLK_DIV` + `SYNC_GAP` cycles.

## Test plan
- Frame 0xAB, 0xC1, 0x23 followed by `dac_set` (`SCLK_DIV` = 2, macro on) → `re_code` = 0xABC, `ref_code` = 0x123; `sdin` words 0x0ABC then 0x4123; `done` after 2·(65+4) = 138 cycles.
- Only two bytes, then `dac_set` → `frame_err` = 1, no `sync_n` activity, codes unchanged; `err_clr` pulse → `frame_err` = 0.
- Four consecutive enabled bytes → `frame_err` = 1; first three bytes retained; commit sends the first-three-byte codes.
- Second valid frame plus `dac_set` during SHIFT → `overrun` = 1; bit stream of the first transfer intact; no second transfer.
- `rst_n` low at the 8th `sclk` of word A → next cycle `sync_n` = 1, `sclk` = 0, `busy` = 0, codes = 0.
- Macro off, frame 0x80, 0x0F, 0xFF → single word 0x0800, `ref_code` = 0xFFF, `done` after 69 cycles.
